updown_extender: RTL and testbench
==================================

# updown_extender

Downstream companion to the 4-bit up/down counter. It samples the counter's `count`, `control` and `load` every clock and tracks wrap-arounds to build a wider extended count. It emits single-cycle overflow and underflow pulses and flags illegal jumps. Notable events are queued in a 2-entry event FIFO with a valid/ready handshake for a consumer such as a logger or display stage.

## Interface
- `HI_W`, default 4: number of extension bits above the counter's 4 bits.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low (asserted at 0).
- `count_in` input 4: counter output `count`.
- `control` input 1: counter direction; 1 = up, 0 = down. This is the same signal that drives the counter.
- `load` input 1: counter load strobe. This is the same signal that drives the counter.
- `ext_count` output HI_W+4: extended count `{hi, lo}`.
- `ovf` output 1: one-cycle pulse when `lo` wraps 15→0 counting up.
- `unf` output 1: one-cycle pulse when `lo` wraps 0→15 counting down.
- `evt_valid` output 1: event FIFO non-empty.
- `evt_code` output 2: head event code. 00 = ovf, 01 = unf, 10 = jump, 11 = extended wrap.
- `evt_ready` input 1: consumer accepts the head event.
- `sticky_err` output 1: set on jump, extended wrap or event drop; cleared only by reset.

## Operation
- **State:**
  - `lo[3:0]`, the last sampled `count_in`.
  - `hi[HI_W-1:0]`.
  - `load_d`, the registered `load`.
  - 2-entry event FIFO.
  - `sticky_err`.
- **Resync (`load_d`=1):**
  - The counter loads on the edge where `load`=1, so the new value is visible one cycle later.
  - When `load_d`=1: `hi`←0, `lo`←`count_in`.
  - No pulses and no event are produced.
- **Otherwise**, let d = (`count_in` − `lo`) mod 16:
  - **d=0:** hold.
  - **d=1 and `control`=1:**
    - `lo`←`count_in`.
    - If `lo`==15: `hi`←`hi`+1, `ovf`=1, enqueue 00.
    - If in addition `hi` is all ones: `hi` wraps to 0, set `sticky_err`, enqueue 11 instead of 00. `ovf` is still pulsed.
  - **d=15 and `control`=0:**
    - `lo`←`count_in`.
    - If `lo`==0: `hi`←`hi`−1, `unf`=1, enqueue 01.
    - If in addition `hi`==0: `hi` wraps to all ones, set `sticky_err`, enqueue 11 instead of 01. `unf` is still pulsed.
  - **Any other d, or a step against `control`:**
    - Jump: `hi`←0, `lo`←`count_in`.
    - Set `sticky_err`, enqueue 10.
    - This covers the counter's own reset to 0.
- **At most one enqueue per cycle.**
- **Event FIFO:**
  - Depth 2, pointer-based, in order.
  - A dequeue occurs when `evt_valid` && `evt_ready`.
  - Enqueue while full with no simultaneous dequeue: the new event is dropped and `sticky_err` is set.
  - Enqueue while full with a simultaneous dequeue: accepted. Occupancy stays at 2.
  - Enqueue and dequeue while occupancy is 1: occupancy stays at 1, and the new event becomes the head.
  - Dequeue while empty: no effect.
- **Arithmetic:** `hi` is modulo 2^HI_W. `ext_count` = `{hi, lo}`, directly registered with no combinational path from inputs.

## Timing
- **Reset values** (`rst`=0 at an edge):
  - `lo`=0, `hi`=0, `load_d`=0.
  - `ext_count`=0, `ovf`=0, `unf`=0.
  - FIFO emptied, `evt_valid`=0, `evt_code`=00.
  - `sticky_err`=0.
- **Reset mid-operation:** discards queued events and an in-flight `load_d`.
- **Latency:** `count_in` sampled at edge N is reflected in `ext_count`, `ovf` and `unf` after edge N. The pulses are high for exactly that one cycle.
- **Event latency:** an event enqueued at edge N is visible on `evt_valid`/`evt_code` after edge N if the FIFO was empty. `evt_code` is stable while `evt_valid`=1 and `evt_ready`=0.
- **Load timing:** `load`=1 at edge N makes the edge N+1 sample a resync. Back-to-back loads resync every cycle.
- **Pulse width:** `ovf` and `unf` are combinationally independent of `evt_ready`. Both are registered and are never high together.

## Test plan
- **Reset, then count up:** release `rst`; count up 0→15→0→1 with `control`=1 and `evt_ready`=1. Required: `ovf` pulses once at the 15→0 sample; `ext_count` goes 0x0F→0x10→0x11; one event 00; `sticky_err`=0.
- **Down-wrap from zero:** from `ext_count`=0x10, count down to 0x0F. Required: `unf` pulses once, event 01. Continue down from 0x00 → 0xFF: `unf`=1, event 11, `sticky_err`=1.
- **Load resync:** from `ext_count`=0x23, `load`=1 with `data_in`=3. Required: the first sample after the load yields `ext_count`=0x03 with no pulse and no event.
- **Illegal jump:** `count_in` goes from 5 to 9 with no load. Required: event 10, `sticky_err`=1, `ext_count`=0x09. A +1 step with `control`=0 also gives event 10.
- **FIFO full with back-pressure:** hold `evt_ready`=0 and produce three ovf events. Required:
  - `evt_valid` stays high with `evt_code`=00.
  - The third event is dropped and `sticky_err`=1.
  - Raising `evt_ready` yields exactly two events.
  - Enqueue and dequeue in the same cycle while full keeps occupancy at 2.
- **Mid-run reset:** assert `rst`=0 for one cycle while two events are queued and `load_d`=1. Required: all outputs return to their reset values on the next cycle; no stale event or resync appears afterwards.

Source files
------------

// File: rtl/updown_extender.sv
// ---------------------------------------------------------------------------
// updown_extender
//
// Sits downstream of a 4-bit up/down counter and widens its count. Every
// clock it samples the counter output together with the counter's own
// direction and load strobes, detects wrap-arounds of the low nibble and
// keeps HI_W extension bits above it. Overflow/underflow are reported as
// one-cycle registered pulses. Wraps, illegal jumps and extension wraps are
// queued in a 2-entry event FIFO drained by a valid/ready consumer.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   count_in    counter output (4 bits)
//   control     counter direction, 1 = up, 0 = down
//   load        counter load strobe (counter shows new value one cycle later)
//   ext_count   registered extended count {hi, lo}
//   ovf / unf   one-cycle pulses on 15->0 up-wrap / 0->15 down-wrap
//   evt_valid   event FIFO non-empty
//   evt_code    head event: 00 ovf, 01 unf, 10 jump, 11 extended wrap
//   evt_ready   consumer accepts the head event
//   sticky_err  latched on jump, extended wrap or dropped event
// ---------------------------------------------------------------------------
module updown_extender #(
    parameter int HI_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      count_in,
    input  logic            control,
    input  logic            load,
    output logic [HI_W+3:0] ext_count,
    output logic            ovf,
    output logic            unf,
    output logic            evt_valid,
    output logic [1:0]      evt_code,
    input  logic            evt_ready,
    output logic            sticky_err
);

    localparam logic [1:0] EVT_OVF  = 2'b00;
    localparam logic [1:0] EVT_UNF  = 2'b01;
    localparam logic [1:0] EVT_JUMP = 2'b10;
    localparam logic [1:0] EVT_XWRP = 2'b11;

    logic [3:0]      lo_q, lo_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic            load_d_q, load_d_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            sticky_q, sticky_d;

    logic [1:0]      mem_q [2];
    logic [1:0]      mem_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;

    logic [3:0]      diff;
    logic            enq;
    logic [1:0]      enq_code;
    logic            err_set;
    logic            deq;
    logic            full;
    logic            drop;
    logic            wr_en;

    // Step classification and extended-count update.
    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        enq      = 1'b0;
        enq_code = EVT_OVF;
        err_set  = 1'b0;
        load_d_d = load;
        diff     = count_in - lo_q;

        if (load_d_q) begin
            // Counter was loaded last edge: restart the extension silently.
            hi_d = '0;
            lo_d = count_in;
        end else if (diff == 4'd0) begin
            lo_d = lo_q;
        end else if (diff == 4'd1 && control) begin
            lo_d = count_in;
            if (lo_q == 4'd15) begin
                hi_d  = hi_q + HI_W'(1);
                ovf_d = 1'b1;
                enq   = 1'b1;
                if (&hi_q) begin
                    enq_code = EVT_XWRP;
                    err_set  = 1'b1;
                end else begin
                    enq_code = EVT_OVF;
                end
            end
        end else if (diff == 4'd15 && !control) begin
            lo_d = count_in;
            if (lo_q == 4'd0) begin
                hi_d  = hi_q - HI_W'(1);
                unf_d = 1'b1;
                enq   = 1'b1;
                if (hi_q == '0) begin
                    enq_code = EVT_XWRP;
                    err_set  = 1'b1;
                end else begin
                    enq_code = EVT_UNF;
                end
            end
        end else begin
            // Anything else (including a step against the direction, or the
            // counter's own reset) cannot be tracked: restart from the sample.
            hi_d     = '0;
            lo_d     = count_in;
            enq      = 1'b1;
            enq_code = EVT_JUMP;
            err_set  = 1'b1;
        end
    end

    // Event FIFO bookkeeping.
    always_comb begin
        full  = (cnt_q == 2'd2);
        deq   = (cnt_q != 2'd0) && evt_ready;
        // A full FIFO still accepts when its head leaves in the same cycle.
        drop  = enq && full && !deq;
        wr_en = enq && !drop;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (wr_en) begin
            mem_d[wr_ptr_q] = enq_code;
        end

        wr_ptr_d = wr_en ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;

        case ({wr_en, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        sticky_d = sticky_q | err_set | drop;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lo_q     <= '0;
            hi_q     <= '0;
            load_d_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            load_d_q <= load_d_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage only; validity is tracked by cnt_q, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q[0] <= mem_d[0];
        mem_q[1] <= mem_d[1];
    end

    assign ext_count  = {hi_q, lo_q};
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign sticky_err = sticky_q;
    assign evt_valid  = (cnt_q != 2'd0);
    // Masked while empty so the idle code is 00.
    assign evt_code   = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : 2'b00;

endmodule

// File: tb/tb_updown_extender.sv
module tb_updown_extender;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       control;
    logic       load;
    logic [7:0] ext_count;
    logic       ovf;
    logic       unf;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       sticky_err;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    updown_extender #(.HI_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .control    (control),
        .load       (load),
        .ext_count  (ext_count),
        .ovf        (ovf),
        .unf        (unf),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ready  (evt_ready),
        .sticky_err (sticky_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted handshake must match the oldest expected code.
    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got code %0d, expected no event", evt_code);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (evt_code !== e) begin
                    errors++;
                    $display("FAIL evt_code: got %0d, expected %0d", evt_code, e);
                end
            end
        end
        if (ovf === 1'b1 && unf === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pulses_exclusive: ovf=%b unf=%b, expected not both", ovf, unf);
        end
    end

    task automatic tick(input logic [3:0] c, input logic ctl, input logic ld, input logic rdy);
        count_in  = c;
        control   = ctl;
        load      = ld;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(4'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(4'd0, 1'b1, 1'b0, 1'b0);
        tick(4'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (ext_count !== 8'h00) begin errors++; $display("FAIL rst_ext: got %h, expected 00", ext_count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, expected 0", ovf); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL rst_unf: got %b, expected 0", unf); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", evt_valid); end
        checks++; if (evt_code !== 2'b00) begin errors++; $display("FAIL rst_code: got %b, expected 00", evt_code); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b, expected 0", sticky_err); end
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        int ovf_seen = 0;
        for (int i = 1; i < 16; i++) begin
            tick(4'(i), 1'b1, 1'b0, 1'b1);
            ovf_seen += int'(ovf);
            checks++;
            if (ext_count !== 8'(i)) begin errors++; $display("FAIL up_ext: got %h, expected %h", ext_count, 8'(i)); end
        end
        checks++; if (ovf_seen != 0) begin errors++; $display("FAIL up_early_ovf: got %0d pulses, expected 0", ovf_seen); end
        exp_q.push_back(2'b00);
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h10) begin errors++; $display("FAIL up_wrap_ext: got %h, expected 10", ext_count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_wrap_ovf: got %b, expected 1", ovf); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b00) begin errors++; $display("FAIL up_wrap_evt: got v=%b c=%b, expected v=1 c=00", evt_valid, evt_code); end
        tick(4'd1, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h11) begin errors++; $display("FAIL up_post_ext: got %h, expected 11", ext_count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_pulse_width: got %b, expected 0", ovf); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL up_drained: got %b, expected 0", evt_valid); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL up_sticky: got %b, expected 0", sticky_err); end
    endtask

    task automatic test_down_wrap();
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h10 || unf !== 1'b0) begin errors++; $display("FAIL dn_step: got %h unf=%b, expected 10 unf=0", ext_count, unf); end
        exp_q.push_back(2'b01);
        tick(4'd15, 1'b0, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h0F) begin errors++; $display("FAIL dn_wrap_ext: got %h, expected 0F", ext_count); end
        checks++; if (unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL dn_wrap_unf: got unf=%b ovf=%b, expected 1 0", unf, ovf); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL dn_wrap_sticky: got %b, expected 0", sticky_err); end
        for (int i = 14; i >= 0; i--) tick(4'(i), 1'b0, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h00) begin errors++; $display("FAIL dn_zero: got %h, expected 00", ext_count); end
        exp_q.push_back(2'b11);
        tick(4'd15, 1'b0, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'hFF) begin errors++; $display("FAIL dn_xwrap_ext: got %h, expected FF", ext_count); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL dn_xwrap_unf: got %b, expected 1", unf); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL dn_xwrap_sticky: got %b, expected 1", sticky_err); end
        tick(4'd15, 1'b0, 1'b0, 1'b1);
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL dn_pulse_width: got %b, expected 0", unf); end
    endtask

    task automatic test_load();
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            if (k % 16 == 0) exp_q.push_back(2'b00);
            tick(4'(k), 1'b1, 1'b0, 1'b1);
        end
        checks++; if (ext_count !== 8'h23) begin errors++; $display("FAIL ld_pre: got %h, expected 23", ext_count); end
        tick(4'd3, 1'b1, 1'b1, 1'b1);
        tick(4'd3, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h03) begin errors++; $display("FAIL ld_resync: got %h, expected 03", ext_count); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("FAIL ld_quiet: got ovf=%b unf=%b v=%b, expected 0 0 0", ovf, unf, evt_valid); end
        tick(4'd3, 1'b1, 1'b1, 1'b1);
        tick(4'd9, 1'b1, 1'b1, 1'b1);
        tick(4'd12, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h0C) begin errors++; $display("FAIL ld_b2b_ext: got %h, expected 0C", ext_count); end
        checks++; if (sticky_err !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("FAIL ld_b2b_quiet: got sticky=%b v=%b, expected 0 0", sticky_err, evt_valid); end
    endtask

    task automatic test_jump();
        do_reset();
        for (int i = 1; i <= 5; i++) tick(4'(i), 1'b1, 1'b0, 1'b1);
        exp_q.push_back(2'b10);
        tick(4'd9, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h09) begin errors++; $display("FAIL jmp_ext: got %h, expected 09", ext_count); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL jmp_sticky: got %b, expected 1", sticky_err); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin errors++; $display("FAIL jmp_evt: got v=%b c=%b, expected v=1 c=10", evt_valid, evt_code); end
        exp_q.push_back(2'b10);
        tick(4'd10, 1'b0, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h0A) begin errors++; $display("FAIL jmp_dir_ext: got %h, expected 0A", ext_count); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin errors++; $display("FAIL jmp_dir_evt: got v=%b c=%b, expected v=1 c=10", evt_valid, evt_code); end
        tick(4'd10, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic up_to_wrap(input logic rdy_last);
        for (int i = 1; i < 16; i++) tick(4'(i), 1'b1, 1'b0, 1'b0);
        tick(4'd0, 1'b1, 1'b0, rdy_last);
    endtask

    task automatic test_fifo_full();
        do_reset();
        exp_q.push_back(2'b00);
        up_to_wrap(1'b0);
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b00) begin errors++; $display("FAIL ff_first: got v=%b c=%b, expected v=1 c=00", evt_valid, evt_code); end
        exp_q.push_back(2'b00);
        up_to_wrap(1'b0);
        checks++; if (sticky_err !== 1'b0 || evt_code !== 2'b00) begin errors++; $display("FAIL ff_second: got sticky=%b c=%b, expected 0 00", sticky_err, evt_code); end
        up_to_wrap(1'b0);
        checks++; if (ext_count !== 8'h30 || ovf !== 1'b1) begin errors++; $display("FAIL ff_third_ext: got %h ovf=%b, expected 30 1", ext_count, ovf); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL ff_drop_sticky: got %b, expected 1", sticky_err); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b00) begin errors++; $display("FAIL ff_hold: got v=%b c=%b, expected v=1 c=00", evt_valid, evt_code); end
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        checks++; if (evt_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL ff_drain: got v=%b pending=%0d, expected 0 0", evt_valid, exp_q.size()); end
        // Refill, then enqueue on the same edge the full FIFO is dequeued.
        exp_q.push_back(2'b00);
        up_to_wrap(1'b0);
        exp_q.push_back(2'b00);
        up_to_wrap(1'b0);
        exp_q.push_back(2'b00);
        up_to_wrap(1'b1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ff_enq_deq: got v=%b, expected 1", evt_valid); end
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ff_occ2: got v=%b, expected 1", evt_valid); end
        tick(4'd0, 1'b1, 1'b0, 1'b1);
        checks++; if (evt_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL ff_occ_end: got v=%b pending=%0d, expected 0 0", evt_valid, exp_q.size()); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        tick(4'd5, 1'b1, 1'b0, 1'b0);
        tick(4'd9, 1'b1, 1'b0, 1'b0);
        tick(4'd9, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        tick(4'd9, 1'b1, 1'b0, 1'b0);
        checks++; if (ext_count !== 8'h00 || ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL mr_outs: got %h ovf=%b unf=%b, expected 00 0 0", ext_count, ovf, unf); end
        checks++; if (evt_valid !== 1'b0 || evt_code !== 2'b00 || sticky_err !== 1'b0) begin errors++; $display("FAIL mr_fifo: got v=%b c=%b sticky=%b, expected 0 00 0", evt_valid, evt_code, sticky_err); end
        rst = 1'b1;
        // Not a legal step from 0, so this must be a jump, not a stale resync.
        exp_q.push_back(2'b10);
        tick(4'd3, 1'b1, 1'b0, 1'b1);
        checks++; if (ext_count !== 8'h03 || sticky_err !== 1'b1) begin errors++; $display("FAIL mr_jump: got %h sticky=%b, expected 03 1", ext_count, sticky_err); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin errors++; $display("FAIL mr_evt: got v=%b c=%b, expected v=1 c=10", evt_valid, evt_code); end
        tick(4'd3, 1'b1, 1'b0, 1'b1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale: got v=%b, expected 0", evt_valid); end
    endtask

    initial begin
        rst       = 1'b0;
        count_in  = 4'd0;
        control   = 1'b1;
        load      = 1'b0;
        evt_ready = 1'b0;
        test_reset();
        test_count_up();
        test_down_wrap();
        tick(4'd15, 1'b0, 1'b0, 1'b1);
        test_load();
        test_jump();
        test_fifo_full();
        test_midrun_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL evt_missing: got %0d undelivered, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
